// File: rtl/memory_slot_controller_pkg.sv
// memory_slot_controller_pkg: shared FSM state encoding and the bus word width
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
package memory_slot_controller_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/memory_timeout_counter.sv
// memory_timeout_counter: counts WAIT cycles and flags the last one before an abort
module memory_timeout_counter #(
    parameter int limit = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int w = $clog2(limit + 1);
    logic [w-1:0] count_q, count_d;
    always_comb count_d = clear ? '0 : enable ? count_q + 1'b1 : count_q;
    always_ff @(posedge clock) begin
        if (!reset_n) count_q <= '0;
        else          count_q <= count_d;
    end
    // expires on the limit-th WAIT cycle, i.e. as the count would reach limit
    assign expired = enable && (count_q == w'(limit - 1));
endmodule

// File: rtl/memory_slot_controller.sv
// memory_slot_controller: single-word memory read/write engine holding the last read word
module memory_slot_controller import memory_slot_controller_pkg::*; #(
    parameter int address_width = 16
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
    , parameter int timeout_cycles = 15
`endif
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     request_valid,
    output logic                     request_ready,
    input  logic                     request_write,
    input  logic [`BIT_WIDTH-1:0]    request_address,
    input  logic [`BIT_WIDTH-1:0]    request_data,
    output logic                     memory_enable,
    output logic                     memory_write,
    output logic [address_width-1:0] memory_address,
    output logic [`BIT_WIDTH-1:0]    memory_write_data,
    input  logic [`BIT_WIDTH-1:0]    memory_read_data,
    input  logic                     memory_acknowledge,
    output logic [`BIT_WIDTH-1:0]    memory_slot,
    output logic                     slot_updated,
    output logic                     busy
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
    , output logic                   timeout_error
`endif
);
    state_t                   state_q, state_d;
    logic                     write_q, write_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [`BIT_WIDTH-1:0]    wdata_q, wdata_d;
    logic [`BIT_WIDTH-1:0]    slot_q, slot_d;
    logic                     upd_q, upd_d;
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
    logic                     timeout_q, timeout_d;
    logic                     expired;
    memory_timeout_counter #(.limit(timeout_cycles)) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state_q == ISSUE),
        .enable  (state_q == WAIT),
        .expired (expired)
    );
    assign timeout_error = timeout_q;
`endif
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        slot_d  = slot_q;
        upd_d   = 1'b0;
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (request_valid) begin
                state_d = ISSUE;
                write_d = request_write;
                addr_d  = request_address[address_width-1:0];
                wdata_d = request_data;
            end
            ISSUE, WAIT: begin
                if (memory_acknowledge) begin
                    state_d = DONE;
                    slot_d  = write_q ? slot_q : memory_read_data;
                    upd_d   = !write_q;
                end
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
                else if (expired) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
`endif
                else state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            slot_q  <= '0;
            upd_q   <= 1'b0;
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            slot_q  <= slot_d;
            upd_q   <= upd_d;
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end
    assign memory_enable     = (state_q == ISSUE) || (state_q == WAIT);
    assign memory_write      = write_q && memory_enable;
    assign memory_address    = addr_q;
    assign memory_write_data = wdata_q;
    assign memory_slot       = slot_q;
    assign slot_updated      = upd_q;
    assign busy              = state_q != IDLE;
    assign request_ready     = reset_n && (state_q == IDLE);
endmodule

// File: tb/tb_memory_slot_controller.sv
// tb_memory_slot_controller: randomized transaction bench against a transaction-level model
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif
module tb_memory_slot_controller;
    localparam int TO = 3;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic request_valid = 1'b0, request_write = 1'b0;
    logic [15:0] request_address = '0, request_data = '0;
    logic memory_enable, memory_write, memory_acknowledge = 1'b0;
    logic [15:0] memory_address, memory_write_data, memory_slot;
    logic [15:0] memory_read_data = '0;
    logic request_ready, slot_updated, busy;
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
    logic timeout_error;
`endif
    memory_slot_controller #(
        .address_width(16)
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
        , .timeout_cycles(TO)
`endif
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .request_valid(request_valid), .request_ready(request_ready),
        .request_write(request_write), .request_address(request_address),
        .request_data(request_data),
        .memory_enable(memory_enable), .memory_write(memory_write),
        .memory_address(memory_address), .memory_write_data(memory_write_data),
        .memory_read_data(memory_read_data), .memory_acknowledge(memory_acknowledge),
        .memory_slot(memory_slot), .slot_updated(slot_updated), .busy(busy)
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
        , .timeout_error(timeout_error)
`endif
    );
    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] rdata;
        int          lat;
        bit          hold;
    } txn_t;

    int tests = 0;
    int failures = 0;
    logic [15:0] model_slot = '0;
    txn_t q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                                input logic [15:0] rdata, input int lat, input bit hold);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data; t.rdata = rdata; t.lat = lat; t.hold = hold;
        return t;
    endfunction

    task automatic drive_req(input txn_t t);
        request_valid   = 1'b1;
        request_write   = t.wr;
        request_address = t.addr;
        request_data    = t.data;
    endtask

    task automatic run_txn(input txn_t t, input bit has_next, input txn_t n);
        int en_n, busy_n, upd_n, to_n;
        bit timed;
        logic [15:0] exp_slot;
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
        timed = t.lat > TO;
`else
        timed = 1'b0;
`endif
        exp_slot = (t.wr || timed) ? model_slot : t.rdata;
        en_n = 0; busy_n = 0; upd_n = 0; to_n = 0;
        check("ready_idle", request_ready, 1);
        drive_req(t);
        memory_acknowledge = ($urandom % 2) == 1;
        memory_read_data   = 16'($urandom);
        @(negedge clock);
        if (t.hold && has_next) drive_req(n);
        else request_valid = 1'b0;
        for (int c = 0; c < 40 && busy; c++) begin
            busy_n++;
            check("ready_busy", request_ready, 0);
            if (slot_updated) upd_n++;
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
            if (timeout_error) to_n++;
`endif
            if (memory_enable) begin
                en_n++;
                check("addr", memory_address, t.addr);
                check("mem_write", memory_write, t.wr);
                if (t.wr) check("wdata", memory_write_data, t.data);
                check("slot_hold", memory_slot, model_slot);
                memory_acknowledge = (en_n == t.lat + 1);
                memory_read_data   = memory_acknowledge ? t.rdata : 16'($urandom);
            end else begin
                check("slot_done", memory_slot, exp_slot);
                memory_acknowledge = ($urandom % 2) == 1;
                memory_read_data   = 16'($urandom);
            end
            @(negedge clock);
        end
        check("busy_bound", busy, 0);
        check("en_cycles", en_n, timed ? TO + 1 : t.lat + 1);
        check("busy_cycles", busy_n, timed ? TO + 2 : t.lat + 2);
        check("upd_pulses", upd_n, (t.wr || timed) ? 0 : 1);
        check("to_pulses", to_n, timed ? 1 : 0);
        check("slot_after", memory_slot, exp_slot);
        check("upd_idle", slot_updated, 0);
        model_slot = exp_slot;
    endtask

    task automatic run_queue();
        for (int i = 0; i < q.size(); i++)
            run_txn(q[i], i + 1 < q.size(), (i + 1 < q.size()) ? q[i + 1] : q[i]);
        request_valid = 1'b0;
        q.delete();
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        check("rst_ready", request_ready, 0);
        check("rst_enable", memory_enable, 0);
        check("rst_write", memory_write, 0);
        check("rst_addr", memory_address, 0);
        check("rst_wdata", memory_write_data, 0);
        check("rst_slot", memory_slot, 0);
        check("rst_upd", slot_updated, 0);
        check("rst_busy", busy, 0);
`ifdef MEMORY_SLOT_CONTROLLER_TIMEOUT_EN
        check("rst_timeout", timeout_error, 0);
`endif
        reset_n = 1'b1;
        @(negedge clock);
        q.push_back(mk(1'b0, 16'h0010, 16'h0000, 16'h00A5, 0, 1'b0));
        q.push_back(mk(1'b0, 16'h0020, 16'h0000, 16'h1234, 4, 1'b0));
        q.push_back(mk(1'b0, 16'h0007, 16'h0000, 16'h0007, 1, 1'b1));
        q.push_back(mk(1'b1, 16'h0003, 16'hBEEF, 16'h5555, 2, 1'b1));
        q.push_back(mk(1'b0, 16'h0100, 16'h0000, 16'hC0DE, 0, 1'b1));
        q.push_back(mk(1'b0, 16'h0200, 16'h0000, 16'hCAFE, 10, 1'b0));
        q.push_back(mk(1'b0, 16'h0300, 16'h0000, 16'h7777, TO, 1'b0));
        run_queue();
        request_valid = 1'b1; request_write = 1'b0; request_address = 16'h0040;
        memory_acknowledge = 1'b0;
        @(negedge clock);
        request_valid = 1'b0;
        @(negedge clock);
        check("mid_wait_en", memory_enable, 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_rst_ready", request_ready, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("mid_rst_en", memory_enable, 0);
        check("mid_rst_slot", memory_slot, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready1", request_ready, 1);
        model_slot = '0;
        for (int i = 0; i < 40; i++)
            q.push_back(mk(($urandom % 2) == 1, 16'($urandom), 16'($urandom), 16'($urandom),
                           int'($urandom_range(0, 6)), ($urandom % 2) == 1));
        run_queue();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
